// File: rtl/interpol_sched_pkg.sv
// Shared definitions for the interpolator rate sequencer.
package interpol_pkg;

  localparam int NFREQW         = 4;
  localparam int DIVW_DFLT      = 8;
  localparam int DIV_RST_DFLT   = 10;
  localparam int NFREQ_RST_DFLT = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A zero interpolation factor would never reach a frame boundary.
  function automatic logic [NFREQW-1:0] clamp_nfreq(input logic [NFREQW-1:0] n);
    return (n == '0) ? NFREQW'(1) : n;
  endfunction

endpackage

// File: rtl/interpol_sched_if.sv
// Configuration handshake between a controller and the rate sequencer.
interface interpol_sched_if #(
  parameter int DIVW = interpol_pkg::DIVW_DFLT
);
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [interpol_pkg::NFREQW-1:0] cfg_nfreq;
  logic [DIVW-1:0]                 cfg_div;

  modport master (output cfg_valid, output cfg_nfreq, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_nfreq, input cfg_div, output cfg_ready);
endinterface

// File: rtl/interpol_sched_rate_div.sv
// Modulo-div counter; wrap flags the last count of each output period.
module rate_div #(
  parameter int DIVW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [DIVW-1:0] div,
  output logic            wrap
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == div - DIVW'(1));

  // Next count: clear wins, otherwise count 0..div-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + DIVW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interpol_sched.sv
// Rate sequencer: output-sample enable every div clocks, input-sample
// enable once per nfreq output samples, with frame-aligned reconfiguration.
//
// state   | meaning
// ST_IDLE | stopped; configuration loads directly into the active registers
// ST_RUN  | sequencing; configuration waits in pending registers for a boundary
module interpol_sched
  import interpol_pkg::*;
#(
  parameter int DIVW      = DIVW_DFLT,
  parameter int DIV_RST   = DIV_RST_DFLT,
  parameter int NFREQ_RST = NFREQ_RST_DFLT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  interpol_sched_if.slave   cfg,
  output logic              endataout,
  output logic              endatain,
  output logic [NFREQW-1:0] phase,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [NFREQW-1:0] nfreq_q, nfreq_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic              pend_q, pend_d;
  logic [NFREQW-1:0] pend_nfreq_q, pend_nfreq_d;
  logic [DIVW-1:0]   pend_div_q, pend_div_d;
  logic [NFREQW-1:0] phase_q, phase_d;
  logic              endataout_q, endataout_d;
  logic              endatain_q, endatain_d;

  logic              cfg_acc;
  logic              cnt_en;
  logic              cnt_clr;
  logic              wrap;
  logic [NFREQW-1:0] cap_nfreq;
  logic [DIVW-1:0]   cap_div;

  // In RUN only one configuration may wait for the next boundary.
  assign cfg.cfg_ready = (state_q == ST_IDLE) || !pend_q;
  assign cfg_acc       = cfg.cfg_valid && cfg.cfg_ready;
  assign cap_nfreq     = clamp_nfreq(cfg.cfg_nfreq);
  // div >= 2 keeps endatain from ever landing on an endataout cycle.
  assign cap_div       = (cfg.cfg_div < DIVW'(2)) ? DIVW'(2) : cfg.cfg_div;
  assign cnt_en        = (state_q == ST_RUN);

  rate_div #(.DIVW(DIVW)) u_rate_div (
    .clock (clock),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .div   (div_q),
    .wrap  (wrap)
  );

  // Next state, frame counter, config capture/apply and enable pulses.
  always_comb begin
    state_d      = state_q;
    nfreq_d      = nfreq_q;
    div_d        = div_q;
    pend_d       = pend_q;
    pend_nfreq_d = pend_nfreq_q;
    pend_div_d   = pend_div_q;
    phase_d      = phase_q;
    endataout_d  = 1'b0;
    endatain_d   = 1'b0;
    cnt_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        phase_d = '0;
        if (cfg_acc) begin
          nfreq_d = cap_nfreq;
          div_d   = cap_div;
        end
        if (run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        endataout_d = wrap;
        // An offer taken on a boundary cycle waits for the following one.
        if (cfg_acc) begin
          pend_d       = 1'b1;
          pend_nfreq_d = cap_nfreq;
          pend_div_d   = cap_div;
        end
        if (endataout_q) begin
          if (phase_q == nfreq_q - NFREQW'(1)) begin
            phase_d    = '0;
            endatain_d = 1'b1;
            if (pend_q) begin
              nfreq_d = pend_nfreq_q;
              div_d   = pend_div_q;
              pend_d  = 1'b0;
              cnt_clr = 1'b1;
            end
            if (!run) begin
              state_d = ST_IDLE;
              cnt_clr = 1'b1;
              if (cfg_acc) begin
                nfreq_d = cap_nfreq;
                div_d   = cap_div;
                pend_d  = 1'b0;
              end
            end
          end else begin
            phase_d = phase_q + NFREQW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      nfreq_q      <= NFREQW'(NFREQ_RST);
      div_q        <= DIVW'(DIV_RST);
      pend_q       <= 1'b0;
      pend_nfreq_q <= '0;
      pend_div_q   <= '0;
      phase_q      <= '0;
      endataout_q  <= 1'b0;
      endatain_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      nfreq_q      <= nfreq_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_nfreq_q <= pend_nfreq_d;
      pend_div_q   <= pend_div_d;
      phase_q      <= phase_d;
      endataout_q  <= endataout_d;
      endatain_q   <= endatain_d;
    end
  end

  assign endataout = endataout_q;
  assign endatain  = endatain_q;
  assign phase     = phase_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_interpol_sched.sv
// Directed bench for interpol_sched: table of IDLE configurations plus
// hand-written mid-frame reconfig, stop and reset sequences.
module tb_interpol_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       endataout;
  logic       endatain;
  logic [3:0] phase;
  logic       busy;

  int checks = 0;
  int errors = 0;

  interpol_sched_if #(.DIVW(8)) cfg_if ();

  interpol_sched #(.DIVW(8), .DIV_RST(10), .NFREQ_RST(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .cfg       (cfg_if),
    .endataout (endataout),
    .endatain  (endatain),
    .phase     (phase),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] nf_in;
    logic [7:0] dv_in;
    int         exp_nf;
    int         exp_dv;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start from IDLE (optionally offering a config) and verify the timing.
  task automatic measure(input bit offer, input logic [3:0] nf_in, input logic [7:0] dv_in,
                         input int nf, input int dv, input string name);
    int n_out, n_in, first_out, first_in, last_out, last_in;
    int bad_out, bad_in, bad_phase, coincide, window;
    cfg_if.cfg_valid = offer;
    cfg_if.cfg_nfreq = nf_in;
    cfg_if.cfg_div   = dv_in;
    run = 1'b1;
    chk({name, "_ready_idle"}, int'(cfg_if.cfg_ready), 1);
    chk({name, "_busy_idle"}, int'(busy), 0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk({name, "_busy_run"}, int'(busy), 1);
    n_out = 0; n_in = 0; first_out = -1; first_in = -1; last_out = -100; last_in = -100;
    bad_out = 0; bad_in = 0; bad_phase = 0; coincide = 0;
    window = 2 * nf * dv + 2;
    for (int c = 1; c <= window; c++) begin
      tick();
      if (endataout && endatain) coincide++;
      if (endatain) begin
        if (n_in == 0) first_in = c;
        else if (c - last_in != nf * dv) bad_in++;
        if (last_out != c - 1) bad_in++;
        last_in = c;
        n_in++;
      end
      if (endataout) begin
        if (n_out == 0) first_out = c;
        else if (c - last_out != dv) bad_out++;
        if (int'(phase) != n_out % nf) bad_phase++;
        last_out = c;
        n_out++;
      end
    end
    chk({name, "_first_out"}, first_out, dv);
    chk({name, "_first_in"}, first_in, nf * dv + 1);
    chk({name, "_out_period"}, bad_out, 0);
    chk({name, "_in_period"}, bad_in, 0);
    chk({name, "_phase"}, bad_phase, 0);
    chk({name, "_coincide"}, coincide, 0);
    chk({name, "_n_in"}, n_in, 2);
  endtask

  task automatic stop_to_idle(input string name);
    int guard;
    run = 1'b0;
    guard = 0;
    while (busy && guard < 1000) begin
      tick();
      guard++;
    end
    chk({name, "_stop"}, int'(busy), 0);
    tick();
    tick();
  endtask

  initial begin
    int outs[$];
    int ins[$];
    int exp_outs[11];
    int exp_ins[3];
    int n_after;

    vecs[0] = '{nf_in: 4'd1,  dv_in: 8'd3, exp_nf: 1,  exp_dv: 3};
    vecs[1] = '{nf_in: 4'd0,  dv_in: 8'd1, exp_nf: 1,  exp_dv: 2};
    vecs[2] = '{nf_in: 4'd2,  dv_in: 8'd0, exp_nf: 2,  exp_dv: 2};
    vecs[3] = '{nf_in: 4'd15, dv_in: 8'd2, exp_nf: 15, exp_dv: 2};
    vecs[4] = '{nf_in: 4'd6,  dv_in: 8'd7, exp_nf: 6,  exp_dv: 7};
    vecs[5] = '{nf_in: 4'd3,  dv_in: 8'd4, exp_nf: 3,  exp_dv: 4};

    reset = 1'b0;
    run = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_nfreq = '0;
    cfg_if.cfg_div   = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_endataout", int'(endataout), 0);
    chk("rst_endatain", int'(endatain), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);

    // Reset defaults: 10 clocks per output, 6 outputs per input.
    measure(1'b0, 4'd0, 8'd0, 6, 10, "dflt");
    stop_to_idle("dflt");

    // Mid-frame reconfig at phase 2: old timing to the boundary, then 5/2.
    exp_outs = '{10, 20, 30, 40, 50, 60, 66, 71, 76, 81, 86};
    exp_ins  = '{61, 72, 82};
    run = 1'b1;
    tick();
    for (int c = 1; c <= 90; c++) begin
      tick();
      if (endataout) outs.push_back(c);
      if (endatain) ins.push_back(c);
      if (c == 25) begin
        chk("mid_phase_at_offer", int'(phase), 2);
        chk("mid_ready_before", int'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_nfreq = 4'd2;
        cfg_if.cfg_div   = 8'd5;
      end
      if (c == 26) begin
        chk("mid_ready_after_acc", int'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
      end
      if (c == 60) chk("mid_ready_at_bnd", int'(cfg_if.cfg_ready), 0);
      if (c == 61) chk("mid_ready_after_bnd", int'(cfg_if.cfg_ready), 1);
    end
    chk("mid_n_out", outs.size(), 11);
    chk("mid_n_in", ins.size(), 3);
    for (int i = 0; i < 11; i++) begin
      if (i < outs.size()) chk($sformatf("mid_out%0d", i), outs[i], exp_outs[i]);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < ins.size()) chk($sformatf("mid_in%0d", i), ins[i], exp_ins[i]);
    end
    stop_to_idle("mid");

    // Configurations offered in IDLE, including clamped values.
    for (int v = 0; v < 6; v++) begin
      measure(1'b1, vecs[v].nf_in, vecs[v].dv_in, vecs[v].exp_nf, vecs[v].exp_dv,
              $sformatf("vec%0d", v));
      stop_to_idle($sformatf("vec%0d", v));
    end

    // Stop request at phase 1 with 4/3 timing: finish the frame, then idle.
    outs.delete();
    ins.delete();
    n_after = 0;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (endataout) outs.push_back(c);
      if (endatain) ins.push_back(c);
      if (c > 13 && (endataout || endatain)) n_after++;
      if (c == 5) begin
        chk("stop_phase_at_req", int'(phase), 1);
        run = 1'b0;
      end
      if (c == 12) chk("stop_busy_at_bnd", int'(busy), 1);
      if (c == 13) chk("stop_busy_after", int'(busy), 0);
    end
    chk("stop_n_out", outs.size(), 3);
    chk("stop_n_in", ins.size(), 1);
    if (ins.size() > 0) chk("stop_in_cycle", ins[0], 13);
    chk("stop_no_pulses_after", n_after, 0);

    // Reset at phase 4 with a config pending: outputs reset, config dropped.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 44; c++) begin
      tick();
      if (c == 42) begin
        chk("rst2_phase", int'(phase), 4);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_nfreq = 4'd2;
        cfg_if.cfg_div   = 8'd5;
      end
      if (c == 43) begin
        chk("rst2_pending", int'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run = 1'b0;
    chk("rst2_endataout", int'(endataout), 0);
    chk("rst2_endatain", int'(endatain), 0);
    chk("rst2_phase_rst", int'(phase), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_ready", int'(cfg_if.cfg_ready), 1);
    measure(1'b0, 4'd0, 8'd0, 6, 10, "restart");
    stop_to_idle("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interpol_sched.md
# interpol_sched

Rate sequencer for the linear interpolator datapath. Generates the output-sample clock enable (`endataout`, one pulse every `div` clocks) and the input-sample clock enable (`endatain`, one pulse per `Nfreq` output pulses), exports the current interpolation phase, and accepts run-time reconfiguration of both ratios. Configuration changes are applied only at input-frame boundaries, so the interpolator never sees a partial frame.

## Interface
- `DIVW`, 8: width of the output-rate divider.
- `DIV_RST`, 10: divider value after reset; gives fclk/10.
- `NFREQ_RST`, 6: interpolation factor after reset.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; asserted when 0.
- `run` in 1: level; 1 starts or keeps sequencing, 0 requests a stop at the next frame boundary.
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: configuration accepted when `cfg_valid & cfg_ready`.
- `cfg_nfreq` in 4: new interpolation factor.
- `cfg_div` in DIVW: new output-rate divider, in clocks.
- `endataout` out 1: one-cycle output-sample enable.
- `endatain` out 1: one-cycle input-sample enable.
- `phase` out 4: index of the last output sample within the frame, 0..nfreq_r-1.
- `busy` out 1: 1 while in RUN.

## Operation
- Reset (`reset`=0 at an edge): state IDLE; `div_cnt`=0; `phase`=0; `endataout`=0; `endatain`=0; `busy`=0; `cfg_ready`=1; `nfreq_r`=NFREQ_RST; `div_r`=DIV_RST. Any pending configuration is discarded.
- Clamps at capture: `cfg_nfreq`=0 is stored as 1; `cfg_div`<2 is stored as 2.
- IDLE:
  - `cfg_ready`=1. An accepted configuration loads `nfreq_r`/`div_r` on the next edge.
  - `run`=1 moves to RUN with `div_cnt`=0 and `phase`=0.
- RUN:
  - `div_cnt` counts 0..`div_r`-1 and wraps.
  - The wrap cycle sets the registered `endataout`=1 for exactly one cycle.
  - On each `endataout` cycle: if `phase`==`nfreq_r`-1 (frame boundary), `phase`←0 and `endatain`←1 for one cycle; otherwise `phase`←`phase`+1.
- Config in RUN:
  - `cfg_ready`=1 only when no configuration is pending.
  - An accepted configuration goes into pending registers and is applied on the frame-boundary edge. From that edge `div_cnt` restarts at 0 with the new `div_r`.
  - A configuration accepted in the same cycle as a boundary becomes pending and is applied at the following boundary.
- Stop:
  - `run`=0 seen at a frame-boundary `endataout` cycle moves to IDLE after that `endatain` is issued. Any pending configuration is applied at the same edge.
  - `run`=0 elsewhere in RUN has no effect until the next boundary.
- `nfreq_r`=1: every `endataout` is a frame boundary, so `endatain` follows every `endataout`.

## Timing
- First `endataout` is `div_r` cycles after the edge that enters RUN.
- `endatain` is high the cycle immediately after the boundary `endataout`. Both are registered and never high in the same cycle. The `div_r`≥2 clamp guarantees this.
- Steady state: `endataout` period = `div_r` clocks; `endatain` period = `div_r`·`nfreq_r` clocks.
- `phase` updates on the edge that ends the `endataout` cycle.
- Config handshake: single-cycle accept. `cfg_ready` drops the cycle after an accept in RUN and rises the cycle after the boundary that applies the configuration.
- Reset mid-frame takes effect on the next edge. All outputs take their reset values in the following cycle.

## Structure
- Shared package `interpol_pkg`:
  - state encoding (IDLE, RUN);
  - DIVW/NFREQ width constants;
  - reset defaults NFREQ_RST and DIV_RST.
- One natural sub-module, `rate_div`: a loadable modulo-`div_r` counter emitting the wrap pulse, with a synchronous clear. The frame counter, config pending logic and FSM stay in `interpol_sched`.

## Test plan
- Reset defaults, `run`=1 held → `endataout` every 10 clocks, first at cycle 10 after entering RUN; `endatain` one cycle after every 6th `endataout` (period 60); `phase` cycles 0..5.
- In IDLE, offer `cfg_nfreq`=3, `cfg_div`=4, then `run`=1 → `endataout` period 4, `endatain` period 12.
- Mid-frame in RUN (phase 2 of 6), offer `cfg_nfreq`=2, `cfg_div`=5 → `cfg_ready` low until the boundary; old 10/6 timing holds until the boundary, then period 5/10.
- `cfg_nfreq`=0, `cfg_div`=1 → stored as 1 and 2; `endataout` every 2 clocks, `endatain` in each gap cycle, never coincident.
- `run`=0 at phase 1 → sequencing continues to the boundary; final `endatain` issued; then IDLE with `busy`=0 and no further pulses.
- `reset`=0 for one cycle at phase 4 → next cycle all outputs at reset values and the pending config is dropped; restart with `run`=1 reproduces the first scenario.
